// File: rtl/sync_pulse_monitor.sv
// Measures the spacing of sync strobes, checks each period against the nominal window,
// and runs a lock FSM that flywheels over isolated missed pulses.
module sync_pulse_monitor #(
    parameter int CNT_W  = 32,
    parameter int NOM    = 1000,
    parameter int TOL    = 2,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             pulse_ok,
    output logic             win_err,
    output logic             missing,
    output logic             locked,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);

    localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(NOM - TOL);
    localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(NOM + TOL);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(NOM + TOL + 1);
    // After a timeout the virtual pulse sat at NOM, so the count resumes TOL+1 cycles later.
    localparam logic [CNT_W-1:0] FLY_CNT = CNT_W'(TOL + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GOOD_W-1:0]  good_q;
    logic [MISS_W-1:0]  miss_q;
    logic [CNT_W-1:0]   period_q;
    logic               period_valid_q;
    logic               pulse_ok_q;
    logic               win_err_q;
    logic               missing_q;
    logic               locked_q;

    logic [CNT_W-1:0]   cnt_d;
    logic [GOOD_W-1:0]  good_d;
    logic [MISS_W-1:0]  miss_d;
    logic               in_win;
    logic               timeout;

    always_comb begin
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        good_d  = good_q + GOOD_W'(1);
        miss_d  = miss_q + MISS_W'(1);
        in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
        timeout = (cnt_q == TMO_CNT) && !pulse_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            miss_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pulse_ok_q     <= 1'b0;
            win_err_q      <= 1'b0;
            missing_q      <= 1'b0;
            locked_q       <= 1'b0;
        end else if (!enable) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            good_q         <= '0;
            miss_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pulse_ok_q     <= 1'b0;
            win_err_q      <= 1'b0;
            missing_q      <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            pulse_ok_q     <= 1'b0;
            win_err_q      <= 1'b0;
            missing_q      <= 1'b0;
            cnt_q          <= cnt_d;

            case (state_q)
                ST_IDLE: begin
                    // First pulse only establishes the reference; no period yet.
                    if (pulse_in) begin
                        state_q <= ST_SEARCH;
                        cnt_q   <= CNT_ONE;
                        good_q  <= '0;
                    end
                end

                ST_SEARCH: begin
                    if (pulse_in) begin
                        period_valid_q <= 1'b1;
                        period_q       <= cnt_q;
                        cnt_q          <= CNT_ONE;
                        if (in_win) begin
                            good_q <= good_d;
                            if (good_d == GOOD_W'(LOCK_N)) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end else begin
                            win_err_q <= 1'b1;
                            good_q    <= '0;
                        end
                    end else if (timeout) begin
                        missing_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        good_q    <= '0;
                    end
                end

                ST_LOCKED: begin
                    if (pulse_in) begin
                        period_valid_q <= 1'b1;
                        period_q       <= cnt_q;
                        cnt_q          <= CNT_ONE;
                        if (in_win) begin
                            pulse_ok_q <= 1'b1;
                            miss_q     <= '0;
                        end else begin
                            win_err_q <= 1'b1;
                            state_q   <= ST_SEARCH;
                            locked_q  <= 1'b0;
                            good_q    <= '0;
                        end
                    end else if (timeout) begin
                        missing_q <= 1'b1;
                        if (miss_d == MISS_W'(LOSS_N)) begin
                            state_q  <= ST_IDLE;
                            locked_q <= 1'b0;
                            cnt_q    <= '0;
                            miss_q   <= '0;
                        end else begin
                            miss_q <= miss_d;
                            cnt_q  <= FLY_CNT;
                        end
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                    cnt_q    <= '0;
                    good_q   <= '0;
                    miss_q   <= '0;
                end
            endcase
        end
    end

    assign period_out   = period_q;
    assign period_valid = period_valid_q;
    assign pulse_ok     = pulse_ok_q;
    assign win_err      = win_err_q;
    assign missing      = missing_q;
    assign locked       = locked_q;
    assign state        = state_q;

endmodule

// File: tb/tb_sync_pulse_monitor.sv
// Bench for sync_pulse_monitor with NOM=10, TOL=1, LOCK_N=3, LOSS_N=2, CNT_W=8:
// a table of pulse/timeout events drives the DUT, expectations flow through a queue.
module tb_sync_pulse_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] period_out;
    logic       period_valid, pulse_ok, win_err, missing, locked;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    sync_pulse_monitor #(
        .CNT_W(8), .NOM(10), .TOL(1), .LOCK_N(3), .LOSS_N(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .period_out(period_out), .period_valid(period_valid), .pulse_ok(pulse_ok),
        .win_err(win_err), .missing(missing), .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idle;
        logic       pulse;
        logic       pv;
        logic [7:0] per;
        logic       ok, err, miss, lock;
        logic [1:0] st;
    } rec_t;

    typedef struct {
        int          idx;
        logic        quiet;
        logic [14:0] vec;
    } exp_t;

    rec_t tbl [0:25];
    exp_t exp_q[$];
    rec_t prev;

    function automatic rec_t mk(int idle, logic pulse, logic pv, logic [7:0] per,
                                logic ok, logic err, logic miss, logic lock, logic [1:0] st);
        rec_t r;
        r.idle = idle; r.pulse = pulse; r.pv = pv; r.per = per;
        r.ok = ok; r.err = err; r.miss = miss; r.lock = lock; r.st = st;
        return r;
    endfunction

    function automatic logic [14:0] pack_rec(rec_t r, logic quiet);
        if (quiet) return {1'b0, r.per, 1'b0, 1'b0, 1'b0, r.lock, r.st};
        return {r.pv, r.per, r.ok, r.err, r.miss, r.lock, r.st};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {period_valid, period_out, pulse_ok, win_err, missing, locked, state};
    endfunction

    // Monitor: the DUT's registered response appears just after the edge that saw the stimulus.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = dut_vec();
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL rec%0d%s: got pv/per/ok/err/miss/lock/st=%b/%0d/%b/%b/%b/%b/%b want %b/%0d/%b/%b/%b/%b/%b",
                             e.idx, e.quiet ? "_quiet" : "",
                             act[14], act[13:6], act[5], act[4], act[3], act[2], act[1:0],
                             e.vec[14], e.vec[13:6], e.vec[5], e.vec[4], e.vec[3], e.vec[2], e.vec[1:0]);
                end else if (!e.quiet) begin
                    $display("rec%0d: pv=%b per=%0d ok=%b err=%b miss=%b lock=%b st=%b",
                             e.idx, act[14], act[13:6], act[5], act[4], act[3], act[2], act[1:0]);
                end
            end
        end
    end

    task automatic chk(string name, logic [14:0] act, logic [14:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end else begin
            $display("%s: %b", name, act);
        end
    endtask

    task automatic run_rec(int idx);
        rec_t r;
        exp_t e;
        r = tbl[idx];
        for (int i = 0; i < r.idle; i++) begin
            @(negedge clk);
            pulse_in = 1'b0;
            e.idx = idx; e.quiet = 1'b1; e.vec = pack_rec(prev, 1'b1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        pulse_in = r.pulse;
        e.idx = idx; e.quiet = 1'b0; e.vec = pack_rec(r, 1'b0);
        exp_q.push_back(e);
        prev = r;
    endtask

    task automatic drain(string name);
        @(negedge clk);
        pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: queue left %0d want 0", name, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        //            idle pulse pv  per ok err miss lock st
        tbl[0]  = mk(3,  1, 0,  0, 0, 0, 0, 0, 2'b01);  // IDLE -> SEARCH, no reference
        tbl[1]  = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[2]  = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[3]  = mk(9,  1, 1, 10, 0, 0, 0, 1, 2'b10);  // third good period locks
        tbl[4]  = mk(9,  1, 1, 10, 1, 0, 0, 1, 2'b10);
        tbl[5]  = mk(8,  1, 1,  9, 1, 0, 0, 1, 2'b10);  // lower window edge
        tbl[6]  = mk(10, 1, 1, 11, 1, 0, 0, 1, 2'b10);  // upper window edge
        tbl[7]  = mk(7,  1, 1,  8, 0, 1, 0, 0, 2'b01);  // out of window drops lock
        tbl[8]  = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[9]  = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[10] = mk(9,  1, 1, 10, 0, 0, 0, 1, 2'b10);
        tbl[11] = mk(11, 0, 0, 10, 0, 0, 1, 1, 2'b10);  // flywheel timeout at cnt=12
        tbl[12] = mk(7,  1, 1, 10, 1, 0, 0, 1, 2'b10);  // back on grid
        tbl[13] = mk(11, 0, 0, 10, 0, 0, 1, 1, 2'b10);  // miss count restarted by pulse_ok
        tbl[14] = mk(9,  0, 0, 10, 0, 0, 1, 0, 2'b00);  // second consecutive miss: loss
        tbl[15] = mk(4,  1, 0, 10, 0, 0, 0, 0, 2'b01);
        tbl[16] = mk(11, 0, 0, 10, 0, 0, 1, 0, 2'b00);  // search timeout
        tbl[17] = mk(2,  1, 0, 10, 0, 0, 0, 0, 2'b01);
        tbl[18] = mk(11, 1, 1, 12, 0, 1, 0, 0, 2'b01);  // pulse on timeout cycle wins
        tbl[19] = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[20] = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[21] = mk(9,  1, 1, 10, 0, 0, 0, 1, 2'b10);
        tbl[22] = mk(2,  1, 0,  0, 0, 0, 0, 0, 2'b01);  // after disable period_out was cleared
        tbl[23] = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[24] = mk(9,  1, 1, 10, 0, 0, 0, 0, 2'b01);
        tbl[25] = mk(9,  1, 1, 10, 0, 0, 0, 1, 2'b10);

        prev = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        repeat (3) @(negedge clk);
        chk("reset_state", dut_vec(), 15'd0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("after_reset_release", dut_vec(), 15'd0);

        for (int i = 0; i <= 21; i++) run_rec(i);
        drain("drain_main");

        // Drop enable while locked: synchronous clear, pulses ignored.
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("enable_low_clear", dut_vec(), 15'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse_in = 1'b1;
            @(negedge clk);
            pulse_in = 1'b0;
            chk($sformatf("disabled_pulse%0d", i), dut_vec(), 15'd0);
        end
        @(negedge clk);
        enable = 1'b1;
        prev = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        for (int i = 22; i <= 25; i++) run_rec(i);
        drain("drain_relock");
        chk("relocked", {13'd0, locked, state[0]}, {13'd0, 1'b1, 1'b0});

        // Asynchronous reset asserted mid-cycle must clear without waiting for an edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_midcycle", dut_vec(), 15'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_async_reset", dut_vec(), 15'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
